pipo_rr_arbiter: RTL and testbench



---
 rtl/pipo_rr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pipo_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter
//   Round-robin arbiter and load sequencer for a shared WIDTH-bit PIPO register.
//   A granted requester's word is loaded into q. The block then stays busy for
//   HOLD_CYCLES cycles, counted from the grant cycle, so consumers can sample q.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [NREQ]        level request per requester
//   d       in   [NREQ*WIDTH]  requester words, requester i at [i*WIDTH +: WIDTH]
//   gnt     out  [NREQ]        one-hot grant pulse (registered)
//   q       out  [WIDTH]       shared register contents
//   q_valid out  1             pulse in the cycle q shows a newly loaded word
//   q_src   out  [SW]          index of the requester whose word is in q
//   busy    out  1             high while holding
//
// Configuration
//   PIPO_ARB_PRIORITY_EN  when defined, requester 0 has absolute priority and
//                         requesters 1..NREQ-1 rotate via ptr, which skips 0.

module pipo_rr_arbiter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    localparam int unsigned SW         = $clog2(NREQ),
    localparam int unsigned CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [SW-1:0]         q_src,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [SW-1:0]     q_src_q, q_src_d;
    logic              busy_q, busy_d;

    // Arbitration signals
    logic [NREQ-1:0]   req_rr;     // requests taking part in the rotation
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;    // req_rr rotated so bit 0 is the ptr position
    logic [SW-1:0]     off;
    logic [SW:0]       win_sum;
    logic [SW-1:0]     win;
    logic              win_found;
    logic [SW:0]       nxt_sum;
    logic [SW-1:0]     ptr_next;

    always_comb begin
`ifdef PIPO_ARB_PRIORITY_EN
        req_rr = req & ~NREQ'(1);
`else
        req_rr = req;
`endif
        // Rotating right by ptr turns "first set bit from ptr upward, wrapping"
        // into a plain lowest-set-bit search.
        req_dbl = {req_rr, req_rr};
        req_rot = req_dbl[NREQ-1:0];
        for (int i = 0; i < NREQ; i++) begin
            if (ptr_q == SW'(i)) begin
                req_rot = req_dbl[i +: NREQ];
            end
        end

        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SW'(i);
            end
        end

        win_sum = {1'b0, ptr_q} + {1'b0, off};
        if (win_sum >= (SW + 1)'(NREQ)) begin
            win_sum = win_sum - (SW + 1)'(NREQ);
        end
        win       = win_sum[SW-1:0];
        win_found = |req_rr;

        nxt_sum = {1'b0, win} + (SW + 1)'(1);
        if (nxt_sum >= (SW + 1)'(NREQ)) begin
            nxt_sum = '0;
        end
        ptr_next = nxt_sum[SW-1:0];

`ifdef PIPO_ARB_PRIORITY_EN
        // The rotation never lands on requester 0.
        if (ptr_next == '0) begin
            ptr_next = SW'(1);
        end
        // Requester 0 overrides the rotation and leaves ptr untouched.
        if (req[0]) begin
            win       = '0;
            win_found = 1'b1;
            ptr_next  = ptr_q;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_src_d   = q_src_q;
        gnt_d     = '0;
        q_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == SW'(i)) begin
                            q_d = d[i*WIDTH +: WIDTH];
                        end
                    end
                    q_src_d   = win;
                    gnt_d     = NREQ'(1) << win;
                    q_valid_d = 1'b1;
                    ptr_d     = ptr_next;
                    cnt_d     = CW'(HOLD_CYCLES - 1);
                    state_d   = StHold;
                end
            end
            StHold: begin
                // req and d are ignored here.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_src_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_src_q   <= q_src_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_src   = q_src_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Testbench for pipo_rr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model.

module tb_pipo_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int HOLD  = 2;
    localparam int SW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [SW-1:0]         q_src;
    logic                  busy;

    always #5 clk = ~clk;

    pipo_rr_arbiter #(
        .WIDTH       (WIDTH),
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_src   (q_src),
        .busy    (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_hold is the number of further edges the block stays busy.
    int              m_ptr;
    int              m_hold;
    logic [NREQ-1:0] m_gnt;
    logic [WIDTH-1:0] m_q;
    logic            m_valid;
    int              m_src;

    int got_order[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [NREQ-1:0] r);
        int w;
`ifdef PIPO_ARB_PRIORITY_EN
        if (r[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            w = (m_ptr + k) % NREQ;
            if (w != 0 && r[w]) return w;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            w = (m_ptr + k) % NREQ;
            if (r[w]) return w;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_hold  = 0;
        m_gnt   = '0;
        m_q     = '0;
        m_valid = 1'b0;
        m_src   = 0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] dv);
        int w;
        m_gnt   = '0;
        m_valid = 1'b0;
        if (m_hold > 0) begin
            m_hold--;
        end else begin
            w = pick_winner(r);
            if (w >= 0) begin
                m_q     = dv[w*WIDTH +: WIDTH];
                m_src   = w;
                m_gnt   = NREQ'(1) << w;
                m_valid = 1'b1;
                m_hold  = HOLD;
`ifdef PIPO_ARB_PRIORITY_EN
                if (w != 0) begin
                    m_ptr = (w + 1) % NREQ;
                    if (m_ptr == 0) m_ptr = 1;
                end
`else
                m_ptr = (w + 1) % NREQ;
`endif
            end
        end
    endtask

    task automatic compare_all();
        check_eq("gnt", 32'(gnt), 32'(m_gnt));
        check_eq("q", 32'(q), 32'(m_q));
        check_eq("q_valid", 32'(q_valid), 32'(m_valid));
        check_eq("q_src", 32'(q_src), 32'(m_src));
        check_eq("busy", 32'(busy), 32'(m_hold > 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(req, d);
        #1;
        compare_all();
        if (q_valid) got_order.push_back(int'(q_src));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        check_eq({tag, "_len"}, 32'(got_order.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_order.size(); i++) begin
            check_eq(tag, 32'(got_order[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_q", 32'(q), 32'(0));
        check_eq("rst_gnt", 32'(gnt), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_q_valid", 32'(q_valid), 32'(0));
        check_eq("rst_q_src", 32'(q_src), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int bound;
        rst_n = 1'b1;
        req   = '0;
        d     = '0;
        model_reset();
        #2;
        do_reset();

        // Single request from requester 0
        req = 4'b0001;
        d   = 16'h0009;
        step();
        check_eq("single_gnt", 32'(gnt), 32'h1);
        check_eq("single_q", 32'(q), 32'h9);
        req = '0;
        steps(4);
        check_eq("single_q_kept", 32'(q), 32'h9);

        // All requesters held high, then wrap with req=1001
        do_reset();
        got_order.delete();
        d   = {4'b1101, 4'b0110, 4'b1001, 4'b0001};
        req = 4'b1111;
        steps(12);
`ifndef PIPO_ARB_PRIORITY_EN
        check_order("order_all", '{0, 1, 2, 3});
        req = 4'b1001;
        steps(6);
        check_order("order_wrap", '{0, 1, 2, 3, 0, 3});
`else
        check_order("order_pri", '{0, 0, 0, 0});
        got_order.delete();
        req = 4'b1110;
        steps(12);
        check_order("order_pri_rr", '{1, 2, 3, 1});
`endif
        req = '0;
        steps(3);

        // A request pulse inside HOLD is lost
        do_reset();
        req = 4'b0100;
        d   = 16'h0500;
        step();
        req = 4'b0010;
        d   = 16'h00a0;
        step();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("hold_ign_valid", 32'(q_valid), 32'(0));
            check_eq("hold_ign_q", 32'(q), 32'h5);
        end

        // Randomized traffic following the requester protocol
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i] && $urandom_range(1, 0) == 0) begin
                    req[i] = 1'b0;
                end else if (req[i] && m_gnt[i]) begin
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i] = 1'b1;
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end

        // Reset asserted mid-HOLD, between clock edges
        req   = 4'b1111;
        bound = 0;
        while (m_hold == 0 && bound < 20) begin
            step();
            bound++;
        end
        check_eq("reach_hold", 32'(m_hold > 0), 32'(1));
        do_reset();
        req = 4'b1111;
        d   = 16'h7ce3;
        step();
        check_eq("post_rst_gnt", 32'(gnt), 32'h1);
        check_eq("post_rst_q", 32'(q), 32'h3);
        steps(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
